// File: rtl/fabric_config_pkg.sv
// Shared definitions for the fabric configuration front end: header layout,
// loader state encoding and frame word width.
package fabric_config_pkg;

    localparam int unsigned FRAME_WORD_W = 32;

    // Header word layout: magic[31:28], column[27:20], frame[19:15], reserved[14:0]
    localparam logic [3:0]  HDR_MAGIC     = 4'hA;
    localparam int unsigned HDR_MAGIC_LSB = 28;
    localparam int unsigned HDR_COL_LSB   = 20;
    localparam int unsigned HDR_FRAME_LSB = 15;
    localparam int unsigned HDR_MAGIC_W   = 4;
    localparam int unsigned HDR_COL_W     = 8;
    localparam int unsigned HDR_FRAME_W   = 5;
    localparam int unsigned HDR_RSVD_W    = 15;

    typedef struct packed {
        logic [HDR_MAGIC_W-1:0] magic;
        logic [HDR_COL_W-1:0]   col;
        logic [HDR_FRAME_W-1:0] frame;
        logic [HDR_RSVD_W-1:0]  rsvd;
    } hdr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR_OK  = 2'd1,
        HDR_BAD = 2'd2,
        STROBE  = 2'd3
    } state_e;

    // Builds a header word for the given column and frame index.
    function automatic logic [FRAME_WORD_W-1:0] make_header(
        input logic [HDR_COL_W-1:0]   col,
        input logic [HDR_FRAME_W-1:0] frame
    );
        hdr_t h;
        h.magic = HDR_MAGIC;
        h.col   = col;
        h.frame = frame;
        h.rsvd  = '0;
        return FRAME_WORD_W'(h);
    endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Combinational (column, frame, enable) to one-hot strobe decoder.
// Ports:
//   col_i    - column address
//   frame_i  - frame index within the column
//   en_i     - strobe enable; output is all-zero when low
//   strobe_o - one-hot strobe, bit index = col*MAX_FRAMES_PER_COL + frame
// Out-of-range addresses produce no strobe.
module frame_strobe_decoder
    import fabric_config_pkg::*;
#(
    parameter int unsigned NUM_COLS           = 10,
    parameter int unsigned MAX_FRAMES_PER_COL = 20
) (
    input  logic [HDR_COL_W-1:0]                    col_i,
    input  logic [HDR_FRAME_W-1:0]                  frame_i,
    input  logic                                    en_i,
    output logic [NUM_COLS*MAX_FRAMES_PER_COL-1:0]  strobe_o
);

    always_comb begin
        strobe_o = '0;
        for (int c = 0; c < int'(NUM_COLS); c++) begin
            for (int f = 0; f < int'(MAX_FRAMES_PER_COL); f++) begin
                if (en_i && (col_i == HDR_COL_W'(c)) && (frame_i == HDR_FRAME_W'(f))) begin
                    strobe_o[c*int'(MAX_FRAMES_PER_COL) + f] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fabric_frame_loader.sv
// Configuration front end: accepts bitstream words over valid/ready, assembles
// a frame in a shadow buffer, then publishes it on FrameData and pulses one
// FrameStrobe line for the addressed column/frame.
// Ports:
//   CLK, RST     - configuration clock, async active-high reset
//   s_data       - bitstream word
//   s_valid      - s_data valid
//   s_ready      - word accepted this cycle when s_valid is also high
//   FrameData    - published frame, row r at [32r+31:32r]
//   FrameStrobe  - one-hot strobe, col*MAX_FRAMES_PER_COL + frame
//   frame_count  - frames strobed since reset, saturating
//   addr_error   - sticky out-of-range header flag
//   busy         - loader not idle
module fabric_frame_loader
    import fabric_config_pkg::*;
#(
    parameter int unsigned NUM_ROWS           = 16,
    parameter int unsigned NUM_COLS           = 10,
    parameter int unsigned MAX_FRAMES_PER_COL = 20
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic [FRAME_WORD_W-1:0]                 s_data,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    output logic [NUM_ROWS*FRAME_WORD_W-1:0]        FrameData,
    output logic [NUM_COLS*MAX_FRAMES_PER_COL-1:0]  FrameStrobe,
    output logic [15:0]                             frame_count,
    output logic                                    addr_error,
    output logic                                    busy
);

    localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned FD_W  = NUM_ROWS * FRAME_WORD_W;
    localparam int unsigned STB_W = NUM_COLS * MAX_FRAMES_PER_COL;

    state_e                 state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [HDR_COL_W-1:0]   col_q, col_d;
    logic [HDR_FRAME_W-1:0] frm_q, frm_d;
    logic [FD_W-1:0]        shadow_q, shadow_d;
    logic [FD_W-1:0]        data_q, data_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   ready_q;
    logic                   busy_q;
    logic [STB_W-1:0]       strobe_q;
    logic [STB_W-1:0]       strobe_c;

    hdr_t                   hdr_c;
    logic                   xfer_c;
    logic                   addr_ok_c;
    logic                   last_row_c;
    logic [ROW_W-1:0]       row_idx_c;
    logic                   unused_rsvd_c;

    assign hdr_c         = hdr_t'(s_data);
    assign unused_rsvd_c = ^hdr_c.rsvd;
    assign xfer_c        = s_valid && ready_q;
    assign addr_ok_c     = (32'(hdr_c.col) < NUM_COLS) && (32'(hdr_c.frame) < MAX_FRAMES_PER_COL);
    assign last_row_c    = (row_q == ROW_W'(NUM_ROWS - 1));
    // First data word lands in the top row.
    assign row_idx_c     = ROW_W'(NUM_ROWS - 1) - row_q;

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        frm_d    = frm_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                // Non-header words are consumed and dropped.
                if (xfer_c && (hdr_c.magic == HDR_MAGIC)) begin
                    col_d = hdr_c.col;
                    frm_d = hdr_c.frame;
                    row_d = '0;
                    if (addr_ok_c) begin
                        state_d = HDR_OK;
                    end else begin
                        state_d = HDR_BAD;
                        err_d   = 1'b1;
                    end
                end
            end
            HDR_OK, HDR_BAD: begin
                if (xfer_c) begin
                    shadow_d[int'(row_idx_c)*FRAME_WORD_W +: FRAME_WORD_W] = s_data;
                    row_d = row_q + ROW_W'(1);
                    if (last_row_c) begin
                        row_d = '0;
                        if (state_q == HDR_OK) begin
                            state_d = STROBE;
                            // Publish including the word accepted this cycle.
                            data_d  = shadow_d;
                            if (cnt_q != 16'hFFFF) begin
                                cnt_d = cnt_q + 16'd1;
                            end
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            STROBE: begin
                state_d = IDLE;
                row_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobe line is decoded from the latched address on entry to STROBE.
    frame_strobe_decoder #(
        .NUM_COLS           (NUM_COLS),
        .MAX_FRAMES_PER_COL (MAX_FRAMES_PER_COL)
    ) u_decoder (
        .col_i    (col_q),
        .frame_i  (frm_q),
        .en_i     (state_d == STROBE),
        .strobe_o (strobe_c)
    );

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            frm_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            strobe_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            frm_q    <= frm_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            ready_q  <= (state_d != STROBE);
            busy_q   <= (state_d != IDLE);
            strobe_q <= strobe_c;
        end
    end

    assign s_ready     = ready_q;
    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign frame_count = cnt_q;
    assign addr_error  = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fabric_frame_loader.sv
module tb_fabric_frame_loader;
    import fabric_config_pkg::*;

    localparam int unsigned NR  = 16;
    localparam int unsigned NC  = 10;
    localparam int unsigned NF  = 20;
    localparam int unsigned FDW = NR * 32;
    localparam int unsigned SW  = NC * NF;

    logic            CLK = 1'b0;
    logic            RST;
    logic [31:0]     s_data;
    logic            s_valid;
    logic            s_ready;
    logic [FDW-1:0]  FrameData;
    logic [SW-1:0]   FrameStrobe;
    logic [15:0]     frame_count;
    logic            addr_error;
    logic            busy;

    fabric_frame_loader #(
        .NUM_ROWS           (NR),
        .NUM_COLS           (NC),
        .MAX_FRAMES_PER_COL (NF)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .frame_count (frame_count),
        .addr_error  (addr_error),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int             idx;
        logic [FDW-1:0] fd;
        logic [15:0]    fc;
    } exp_t;

    exp_t           exp_q[$];
    int             strobes[$];
    int             n_pass    = 0;
    int             n_total   = 0;
    int             cyc       = 0;
    int             last_acc  = -100;
    int             ready_low = 0;
    logic [FDW-1:0] model_fd  = '0;
    logic [15:0]    model_fc  = '0;
    exp_t           mon_e;
    logic [SW-1:0]  mon_sv;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [FDW-1:0] act, input logic [FDW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitor: every strobe cycle pops one expected frame.
    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            if (s_ready === 1'b0) ready_low++;
            if (FrameStrobe !== '0) begin
                strobes.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_strobe: got %h expected none", FrameStrobe);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_sv = '0;
                    mon_sv[mon_e.idx] = 1'b1;
                    chk("strobe_onehot", FDW'(FrameStrobe), FDW'(mon_sv));
                    chk("strobe_framedata", FrameData, mon_e.fd);
                    chk("strobe_frame_count", FDW'(frame_count), FDW'(mon_e.fc));
                    chk("strobe_latency", FDW'(cyc), FDW'(last_acc));
                end
            end
        end
    end

    // Drive one word; optional idle gap first; bounded wait for s_ready.
    task automatic send_word(input logic [31:0] w, input int gap);
        int budget;
        repeat (gap) begin
            s_valid = 1'b0;
            @(posedge CLK); #1;
        end
        s_valid = 1'b1;
        s_data  = w;
        budget  = 0;
        while (s_ready !== 1'b1 && budget < 100) begin
            @(posedge CLK); #1;
            budget++;
        end
        if (s_ready !== 1'b1) begin
            n_total++;
            $display("FAIL send_timeout: got s_ready=%b expected 1", s_ready);
        end else begin
            @(posedge CLK); #1;
            last_acc = cyc;
        end
    endtask

    // Header plus nwords data words base+k; pushes the expected strobe for full good frames.
    task automatic send_frame(input int col, input int frm, input logic [31:0] base,
                              input int nwords, input int maxgap);
        exp_t           e;
        logic [FDW-1:0] fd;
        fd = model_fd;
        for (int k = 0; k < int'(NR); k++) fd[(int'(NR) - 1 - k)*32 +: 32] = base + 32'(k);
        if (col < int'(NC) && frm < int'(NF) && nwords == int'(NR)) begin
            model_fd = fd;
            if (model_fc != 16'hFFFF) model_fc = model_fc + 16'd1;
            e.idx = col * int'(NF) + frm;
            e.fd  = fd;
            e.fc  = model_fc;
            exp_q.push_back(e);
        end
        send_word(make_header(8'(col), 5'(frm)), 0);
        for (int k = 0; k < nwords; k++) begin
            send_word(base + 32'(k), (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("ready_in_reset", FDW'(s_ready), FDW'(1'b0));
        @(negedge CLK) RST = 1'b0;
        @(posedge CLK); #1;
        chk("rst_framedata", FrameData, '0);
        chk("rst_strobe", FDW'(FrameStrobe), '0);
        chk("rst_frame_count", FDW'(frame_count), '0);
        chk("rst_addr_error", FDW'(addr_error), '0);
        chk("rst_busy", FDW'(busy), '0);
        chk("rst_ready_after", FDW'(s_ready), FDW'(1'b1));

        // Basic frame: col 3 frame 5 -> strobe bit 65
        send_frame(3, 5, 32'h1000, 16, 0);
        idle(3);
        chk("t1_row15", FDW'(FrameData[511:480]), FDW'(32'h1000));
        chk("t1_row0", FDW'(FrameData[31:0]), FDW'(32'h100F));
        chk("t1_frame_count", FDW'(frame_count), FDW'(16'd1));
        chk("t1_addr_error", FDW'(addr_error), '0);

        // Bad column, then bad frame index; both dropped
        send_frame(12, 0, 32'h2000, 16, 0);
        idle(3);
        chk("bad_addr_error", FDW'(addr_error), FDW'(1'b1));
        chk("bad_framedata", FrameData, model_fd);
        chk("bad_frame_count", FDW'(frame_count), FDW'(16'd1));
        send_frame(0, 20, 32'h2100, 16, 0);
        idle(3);
        chk("badfrm_frame_count", FDW'(frame_count), FDW'(16'd1));
        send_frame(0, 0, 32'h3000, 16, 0);
        idle(3);
        chk("after_bad_sticky", FDW'(addr_error), FDW'(1'b1));

        // Garbage in IDLE
        send_word(32'h0000_0000, 0);
        chk("garbage0_busy", FDW'(busy), '0);
        send_word(32'hFFFF_FFFF, 0);
        chk("garbage1_busy", FDW'(busy), '0);
        send_word(32'h5A00_0000, 0);
        chk("garbage2_busy", FDW'(busy), '0);
        send_frame(9, 19, 32'h4000, 16, 0);
        idle(3);

        // Back-to-back with s_valid held high
        ready_low = 0;
        send_frame(1, 2, 32'h5000, 16, 0);
        send_frame(2, 3, 32'h6000, 16, 0);
        idle(4);
        chk("b2b_ready_low_cycles", FDW'(ready_low), FDW'(2));
        chk("b2b_strobe_spacing", FDW'(strobes[strobes.size()-1] - strobes[strobes.size()-2]), FDW'(18));

        // Reset after 7 data words
        send_frame(4, 4, 32'h7000, 7, 0);
        s_valid = 1'b0;
        RST = 1'b1;
        #1;
        chk("midrst_framedata", FrameData, '0);
        chk("midrst_strobe", FDW'(FrameStrobe), '0);
        chk("midrst_busy", FDW'(busy), '0);
        chk("midrst_ready", FDW'(s_ready), '0);
        model_fd = '0;
        model_fc = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST = 1'b0;
        @(posedge CLK); #1;
        chk("midrst_addr_error", FDW'(addr_error), '0);
        chk("midrst_frame_count", FDW'(frame_count), '0);
        send_frame(3, 5, 32'h1000, 16, 0);
        idle(3);

        // Same frame with random stalls inside the frame
        send_frame(3, 5, 32'h1000, 16, 5);
        idle(3);
        chk("stall_frame_count", FDW'(frame_count), FDW'(16'd2));
        chk("stall_row7", FDW'(FrameData[255:224]), FDW'(32'h1008));

        idle(5);
        chk("scoreboard_empty", FDW'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
